stack_seq: RTL and testbench
============================

STACK_SEQ -- requirements
Module: stack_seq

Interface
REQ-001 SHALL have clk  input  1  system clock; all state updates on posedge clk.
REQ-002 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have start  input  1  one-cycle request to begin a multi-register transfer; sampled only in IDLE.
REQ-004 SHALL have op  input  1  0 = PUSHM (registers to stack), 1 = POPM (stack to registers); sampled with start.
REQ-005 SHALL have reg_mask  input  16  register list, bit i selects register i; sampled with start.
REQ-006 SHALL have rf_raddr  output  4  register-file read index; rf_rdata is combinational from it.
REQ-007 SHALL have rf_rdata  input  32  register-file read data.
REQ-008 SHALL have rf_we, rf_waddr, rf_wdata  output  1/4/32  register-file write port.
REQ-009 SHALL have stk_push, stk_pop, stk_wdata  output  1/1/32  stack command port; at most one of push/pop per cycle.
REQ-010 SHALL have stk_rdata  input  32  flopped stack read data; valid the cycle after stk_pop.
REQ-011 SHALL have busy, done, stall  output  1  busy = state not IDLE; done = one-cycle completion pulse; stall = busy | start.
REQ-012 SHALL have err_ovf, err_unf  output  1  sticky overflow/underflow flags, cleared on next accepted start.

Function
REQ-013 SHALL implement states IDLE, PUSH, POP, DRAIN, DONE.
REQ-014 IDLE + start: latch mask/op; go to PUSH (op=0) or POP (op=1); empty mask goes directly to DONE with no stack traffic.
REQ-015 PUSH: one register per cycle in ascending index; rf_raddr = lowest remaining set bit, stk_wdata = rf_rdata, stk_push = 1; clear that bit; after last bit go to DONE.
REQ-016 POP: one stk_pop per cycle in descending index (highest remaining set bit first); after the last pop go to DRAIN.
REQ-017 Pop writeback: the cycle after each stk_pop, rf_we = 1, rf_waddr = index popped previous cycle, rf_wdata = stk_rdata; pops and writebacks overlap.
REQ-018 DRAIN: perform final writeback, go to DONE; DONE: done = 1 for one cycle, return to IDLE.
REQ-019 A transfer of N registers SHALL take N+1 cycles (PUSHM) or N+2 cycles (POPM) from the cycle after start to done, inclusive.
REQ-020 start while busy SHALL be ignored; no queuing.
REQ-021 Internal depth counter (11 bit, 0..1024) SHALL increment per stk_push, decrement per stk_pop.
REQ-022 Push with depth == 1024: no stk_push, set err_ovf, go to DONE (remaining bits dropped).
REQ-023 Pop with depth == 0: no stk_pop, set err_unf, go to DRAIN if a writeback is pending, else DONE.
REQ-024 Outside active states stk_push, stk_pop, rf_we SHALL be 0; data outputs 0.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, depth 0, latched mask 0, all outputs 0, including mid-transfer; the aborted transfer is not resumed.

Configuration
REQ-026 With STACK_SEQ_BOUNDS_EN defined: depth counter, REQ-022/023 checks and error flags present.
REQ-027 Without STACK_SEQ_BOUNDS_EN: no depth counter, err_ovf/err_unf tied 0, every selected register issues its push/pop unconditionally.

Structure
REQ-028 Shared package stack_pkg SHALL hold STACK_DEPTH = 1024, depth width 11, REG_CNT = 16, op encodings, and the state enum.
REQ-029 Sub-module mask_pri_enc SHALL give lowest or highest set index of a 16-bit mask plus a none flag; instantiated once, direction selected by op.

Verification
REQ-030 PUSHM mask 16'h0025, r0=A, r2=B, r5=C: stk_push in cycles 1-3 with wdata A,B,C; done in cycle 4; depth 3.
REQ-031 POPM mask 16'h0025 after REQ-030: pops cycles 1-3; rf writes r5=C, r2=B, r0=A in cycles 2-4; done cycle 5; depth 0.
REQ-032 start with mask 0: no push/pop/rf_we; done the cycle after start; busy high one cycle.
REQ-033 Depth 1022, PUSHM mask 16'h000F (bounds on): 2 pushes (r0,r1), err_ovf = 1, done; depth 1024; next start clears err_ovf.
REQ-034 Depth 1, POPM mask 16'h0003: pop r1, err_unf, r1 written from stk_rdata, r0 untouched, done.
REQ-035 rst_n low mid-POPM: outputs 0 same cycle, IDLE after release; start during busy has no effect.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared types and constants for the multi-register stack sequencer.
// Bounds checking is enabled by defining STACK_SEQ_BOUNDS_EN.
package stack_pkg;

  localparam int STACK_DEPTH = 1024;
  localparam int DEPTH_W     = 11;
  localparam int REG_CNT     = 16;
  localparam int IDX_W       = 4;
  localparam int DATA_W      = 32;

  localparam logic OP_PUSHM = 1'b0;
  localparam logic OP_POPM  = 1'b1;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_PUSH  = 3'd1;
  localparam state_t ST_POP   = 3'd2;
  localparam state_t ST_DRAIN = 3'd3;
  localparam state_t ST_DONE  = 3'd4;

  function automatic logic [REG_CNT-1:0] idx_bit(
    input logic [IDX_W-1:0] i
  );
    return REG_CNT'(1) << i;
  endfunction

endpackage

// File: rtl/stack_seq_if.sv
// Request, register-file and stack ports of the stack sequencer.
// slave = the sequencer, master = the surrounding core.
interface stack_seq_if;
  import stack_pkg::*;

  logic               start;
  logic               op;
  logic [REG_CNT-1:0] reg_mask;
  logic [IDX_W-1:0]   rf_raddr;
  logic [DATA_W-1:0]  rf_rdata;
  logic               rf_we;
  logic [IDX_W-1:0]   rf_waddr;
  logic [DATA_W-1:0]  rf_wdata;
  logic               stk_push;
  logic               stk_pop;
  logic [DATA_W-1:0]  stk_wdata;
  logic [DATA_W-1:0]  stk_rdata;
  logic               busy;
  logic               done;
  logic               stall;
  logic               err_ovf;
  logic               err_unf;

  modport master (
    output start, op, reg_mask,
    output rf_rdata, stk_rdata,
    input  rf_raddr, rf_we,
    input  rf_waddr, rf_wdata,
    input  stk_push, stk_pop,
    input  stk_wdata,
    input  busy, done, stall,
    input  err_ovf, err_unf
  );

  modport slave (
    input  start, op, reg_mask,
    input  rf_rdata, stk_rdata,
    output rf_raddr, rf_we,
    output rf_waddr, rf_wdata,
    output stk_push, stk_pop,
    output stk_wdata,
    output busy, done, stall,
    output err_ovf, err_unf
  );

endinterface

// File: rtl/stack_seq_pri_enc.sv
// Lowest/highest set-bit finder for a register mask.
// hi=1 selects the highest set index, hi=0 the lowest.
module mask_pri_enc
  import stack_pkg::*;
(
  input  logic [REG_CNT-1:0] mask,
  input  logic               hi,
  output logic [IDX_W-1:0]   idx,
  output logic               none
);

  // Later loop hits override earlier ones, so scan order picks the end.
  always_comb begin
    idx  = '0;
    none = (mask == '0);
    if (hi) begin
      for (int i = 0; i < REG_CNT; i++)
        if (mask[i]) idx = IDX_W'(i);
    end else begin
      for (int i = REG_CNT - 1; i >= 0; i--)
        if (mask[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/stack_seq.sv
// PUSHM/POPM sequencer moving masked registers to/from a stack.
// Define STACK_SEQ_BOUNDS_EN for depth tracking and error flags.
module stack_seq
  import stack_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  stack_seq_if.slave  io
);

  state_t             state_q, state_d;
  logic [REG_CNT-1:0] mask_q, mask_d;
  logic               op_q, op_d;
  logic               wb_vld_q, wb_vld_d;
  logic [IDX_W-1:0]   wb_idx_q, wb_idx_d;
  logic               push_c, pop_c;
  logic               ovf_set, unf_set, clr_err;
  logic [IDX_W-1:0]   enc_idx;
  logic               enc_none;
  logic               room, avail;
  logic               busy;

  mask_pri_enc u_enc (
    .mask (mask_q),
    .hi   (op_q == OP_POPM),
    .idx  (enc_idx),
    .none (enc_none)
  );

`ifdef STACK_SEQ_BOUNDS_EN
  logic [DEPTH_W-1:0] depth_q;
  logic               err_ovf_q, err_unf_q;

  assign room  = (depth_q != DEPTH_W'(STACK_DEPTH));
  assign avail = (depth_q != '0);

  // Track stack occupancy from the commands we issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      depth_q <= '0;
    else if (push_c)
      depth_q <= depth_q + DEPTH_W'(1);
    else if (pop_c)
      depth_q <= depth_q - DEPTH_W'(1);
  end

  // Sticky error flags, cleared when a new transfer is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
    end else if (clr_err) begin
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
    end else begin
      if (ovf_set) err_ovf_q <= 1'b1;
      if (unf_set) err_unf_q <= 1'b1;
    end
  end

  assign io.err_ovf = err_ovf_q;
  assign io.err_unf = err_unf_q;
`else
  logic unused_err;

  assign room       = 1'b1;
  assign avail      = 1'b1;
  assign unused_err = ^{ovf_set, unf_set, clr_err};
  assign io.err_ovf = 1'b0;
  assign io.err_unf = 1'b0;
`endif

  // Next-state, mask consumption and stack command generation.
  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    op_d     = op_q;
    wb_vld_d = 1'b0;
    wb_idx_d = wb_idx_q;
    push_c   = 1'b0;
    pop_c    = 1'b0;
    ovf_set  = 1'b0;
    unf_set  = 1'b0;
    clr_err  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (io.start) begin
          clr_err = 1'b1;
          mask_d  = io.reg_mask;
          op_d    = io.op;
          if (io.reg_mask == '0)
            state_d = ST_DONE;
          else if (io.op == OP_POPM)
            state_d = ST_POP;
          else
            state_d = ST_PUSH;
        end
      end
      ST_PUSH: begin
        if (enc_none) begin
          state_d = ST_DONE;
        end else if (!room) begin
          ovf_set = 1'b1;
          mask_d  = '0;
          state_d = ST_DONE;
        end else begin
          push_c = 1'b1;
          mask_d = mask_q & ~idx_bit(enc_idx);
          if (mask_d == '0) state_d = ST_DONE;
        end
      end
      ST_POP: begin
        if (enc_none) begin
          state_d = wb_vld_q ? ST_DRAIN : ST_DONE;
        end else if (!avail) begin
          unf_set = 1'b1;
          mask_d  = '0;
          state_d = wb_vld_q ? ST_DRAIN : ST_DONE;
        end else begin
          pop_c    = 1'b1;
          wb_vld_d = 1'b1;
          wb_idx_d = enc_idx;
          mask_d   = mask_q & ~idx_bit(enc_idx);
          if (mask_d == '0) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Sequencer state; reset aborts any transfer in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      mask_q   <= '0;
      op_q     <= OP_PUSHM;
      wb_vld_q <= 1'b0;
      wb_idx_q <= '0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      op_q     <= op_d;
      wb_vld_q <= wb_vld_d;
      wb_idx_q <= wb_idx_d;
    end
  end

  assign busy         = (state_q != ST_IDLE);
  assign io.busy      = busy;
  assign io.done      = (state_q == ST_DONE);
  assign io.stall     = busy | io.start;
  assign io.stk_push  = push_c;
  assign io.stk_pop   = pop_c;
  assign io.stk_wdata = push_c ? io.rf_rdata : '0;
  assign io.rf_raddr  = (state_q == ST_PUSH) ? enc_idx : '0;
  assign io.rf_we     = wb_vld_q;
  assign io.rf_waddr  = wb_vld_q ? wb_idx_q : '0;
  assign io.rf_wdata  = wb_vld_q ? io.stk_rdata : '0;

endmodule

// File: tb/tb_stack_seq.sv
// Self-checking bench for stack_seq: vector table plus corner sequences.
// Overflow/underflow sequences run only with STACK_SEQ_BOUNDS_EN.
module tb_stack_seq;
  import stack_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rf_init = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  stack_seq_if sif ();

  stack_seq u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (sif)
  );

  always #5 clk = ~clk;

  logic [31:0] regs [16];
  logic [31:0] mem [2048];
  int          sp;

  assign sif.rf_rdata = regs[sif.rf_raddr];

  always @(posedge clk) begin
    if (rf_init) begin
      for (int i = 0; i < 16; i++)
        regs[i] <= 32'hC0DE_0000 | 32'(i);
    end else if (sif.rf_we) begin
      regs[sif.rf_waddr] <= sif.rf_wdata;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp            <= 0;
      sif.stk_rdata <= '0;
    end else if (sif.stk_push) begin
      mem[11'(sp)] <= sif.stk_wdata;
      sp           <= sp + 1;
    end else if (sif.stk_pop) begin
      sif.stk_rdata <= mem[11'(sp - 1)];
      sp            <= sp - 1;
    end
  end

  logic        r_push [64];
  logic        r_pop  [64];
  logic        r_we   [64];
  logic [31:0] r_wd   [64];
  logic [31:0] r_rfd  [64];
  logic [3:0]  r_wa   [64];

  typedef struct {
    logic        op;
    logic [15:0] mask;
    int          lat;
    int          np;
    int          npop;
    int          nwe;
    int          sp;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    sif.start    = 1'b0;
    sif.op       = 1'b0;
    sif.reg_mask = '0;
    rst_n        = 1'b0;
    rf_init      = 1'b1;
    repeat (3) @(negedge clk);
    rst_n   = 1'b1;
    rf_init = 1'b0;
  endtask

  task automatic do_xfer(input logic o, input logic [15:0] m,
                         input int budget, input int poke,
                         output int lat, output int np,
                         output int npop, output int nwe);
    lat  = -1;
    np   = 0;
    npop = 0;
    nwe  = 0;
    for (int k = 0; k < 64; k++) begin
      r_push[k] = 1'b0;
      r_pop[k]  = 1'b0;
      r_we[k]   = 1'b0;
      r_wd[k]   = '0;
      r_rfd[k]  = '0;
      r_wa[k]   = '0;
    end
    @(negedge clk);
    sif.start    = 1'b1;
    sif.op       = o;
    sif.reg_mask = m;
    #1 chk("stall_on_start", 32'(sif.stall), 32'd1);
    @(negedge clk);
    sif.start    = 1'b0;
    sif.reg_mask = '0;
    for (int c = 1; c <= budget; c++) begin
      if (c < 64) begin
        r_push[c] = sif.stk_push;
        r_pop[c]  = sif.stk_pop;
        r_we[c]   = sif.rf_we;
        r_wd[c]   = sif.stk_wdata;
        r_rfd[c]  = sif.rf_wdata;
        r_wa[c]   = sif.rf_waddr;
      end
      np   += int'(sif.stk_push);
      npop += int'(sif.stk_pop);
      nwe  += int'(sif.rf_we);
      if (sif.done) begin
        lat = c;
        break;
      end
      if (c == poke) begin
        sif.start    = 1'b1;
        sif.op       = ~o;
        sif.reg_mask = 16'hFFFF;
      end else begin
        sif.start    = 1'b0;
        sif.reg_mask = '0;
      end
      @(negedge clk);
    end
    sif.start    = 1'b0;
    sif.reg_mask = '0;
    if (lat < 0) begin
      n_chk++;
      n_err++;
      $display("FAIL done_timeout: got no done within %0d cycles", budget);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1);
  end

  initial begin
    int lat, np, npop, nwe;
    logic [31:0] exp_d [4];
    logic [3:0]  exp_a [4];

    tbl[0] = '{1'b0, 16'h0025,  4,  3,  0,  0,  3};
    tbl[1] = '{1'b1, 16'h0025,  5,  0,  3,  3,  0};
    tbl[2] = '{1'b0, 16'h0000,  1,  0,  0,  0,  0};
    tbl[3] = '{1'b1, 16'h0000,  1,  0,  0,  0,  0};
    tbl[4] = '{1'b0, 16'h8001,  3,  2,  0,  0,  2};
    tbl[5] = '{1'b0, 16'hFFFF, 17, 16,  0,  0, 18};
    tbl[6] = '{1'b1, 16'h8001,  4,  0,  2,  2, 16};
    tbl[7] = '{1'b1, 16'hFFFF, 18,  0, 16, 16,  0};
    tbl[8] = '{1'b0, 16'h0080,  2,  1,  0,  0,  1};
    tbl[9] = '{1'b1, 16'h0080,  3,  0,  1,  1,  0};

    do_reset();
    @(negedge clk);
    chk("rst_busy",   32'(sif.busy),     32'd0);
    chk("rst_done",   32'(sif.done),     32'd0);
    chk("rst_stall",  32'(sif.stall),    32'd0);
    chk("rst_push",   32'(sif.stk_push), 32'd0);
    chk("rst_pop",    32'(sif.stk_pop),  32'd0);
    chk("rst_we",     32'(sif.rf_we),    32'd0);
    chk("rst_raddr",  32'(sif.rf_raddr), 32'd0);
    chk("rst_wdata",  sif.stk_wdata,     32'd0);
    chk("rst_ovf",    32'(sif.err_ovf),  32'd0);
    chk("rst_unf",    32'(sif.err_unf),  32'd0);

    for (int v = 0; v < 10; v++) begin
      do_xfer(tbl[v].op, tbl[v].mask, 40, -1, lat, np, npop, nwe);
      chk($sformatf("v%0d_lat", v),  32'(lat),  32'(tbl[v].lat));
      chk($sformatf("v%0d_push", v), 32'(np),   32'(tbl[v].np));
      chk($sformatf("v%0d_pop", v),  32'(npop), 32'(tbl[v].npop));
      chk($sformatf("v%0d_we", v),   32'(nwe),  32'(tbl[v].nwe));
      chk($sformatf("v%0d_sp", v),   32'(sp),   32'(tbl[v].sp));
    end

    do_reset();
    do_xfer(1'b0, 16'h0025, 20, -1, lat, np, npop, nwe);
    exp_d[1] = 32'hC0DE_0000;
    exp_d[2] = 32'hC0DE_0002;
    exp_d[3] = 32'hC0DE_0005;
    chk("pushm_lat", 32'(lat), 32'd4);
    for (int c = 1; c <= 3; c++) begin
      chk($sformatf("pushm_c%0d_push", c), 32'(r_push[c]), 32'd1);
      chk($sformatf("pushm_c%0d_data", c), r_wd[c], exp_d[c]);
    end
    chk("pushm_sp", 32'(sp), 32'd3);

    do_xfer(1'b1, 16'h0025, 20, -1, lat, np, npop, nwe);
    exp_a[2] = 4'd5;
    exp_a[3] = 4'd2;
    exp_a[1] = 4'd0;
    exp_d[2] = 32'hC0DE_0005;
    exp_d[3] = 32'hC0DE_0002;
    exp_d[1] = 32'hC0DE_0000;
    chk("popm_lat", 32'(lat), 32'd5);
    chk("popm_c1_we", 32'(r_we[1]), 32'd0);
    for (int c = 1; c <= 3; c++)
      chk($sformatf("popm_c%0d_pop", c), 32'(r_pop[c]), 32'd1);
    for (int c = 2; c <= 4; c++) begin
      chk($sformatf("popm_c%0d_we", c), 32'(r_we[c]), 32'd1);
      chk($sformatf("popm_c%0d_addr", c), 32'(r_wa[c]),
          32'(exp_a[c == 4 ? 1 : c]));
      chk($sformatf("popm_c%0d_data", c), r_rfd[c],
          exp_d[c == 4 ? 1 : c]);
    end
    chk("popm_sp", 32'(sp), 32'd0);

`ifdef STACK_SEQ_BOUNDS_EN
    do_reset();
    for (int t = 0; t < 63; t++)
      do_xfer(1'b0, 16'hFFFF, 40, -1, lat, np, npop, nwe);
    do_xfer(1'b0, 16'h3FFF, 40, -1, lat, np, npop, nwe);
    chk("fill_sp", 32'(sp), 32'd1022);
    do_xfer(1'b0, 16'h000F, 20, -1, lat, np, npop, nwe);
    chk("ovf_push", 32'(np), 32'd2);
    chk("ovf_d0", r_wd[1], 32'hC0DE_0000);
    chk("ovf_d1", r_wd[2], 32'hC0DE_0001);
    chk("ovf_c3_push", 32'(r_push[3]), 32'd0);
    chk("ovf_flag", 32'(sif.err_ovf), 32'd1);
    chk("ovf_sp", 32'(sp), 32'd1024);
    do_xfer(1'b0, 16'h0000, 20, -1, lat, np, npop, nwe);
    chk("ovf_clear", 32'(sif.err_ovf), 32'd0);

    do_reset();
    do_xfer(1'b0, 16'h0001, 20, -1, lat, np, npop, nwe);
    do_xfer(1'b1, 16'h0003, 20, -1, lat, np, npop, nwe);
    chk("unf_pop", 32'(npop), 32'd1);
    chk("unf_we", 32'(nwe), 32'd1);
    chk("unf_addr", 32'(r_wa[2]), 32'd1);
    chk("unf_data", r_rfd[2], 32'hC0DE_0000);
    chk("unf_flag", 32'(sif.err_unf), 32'd1);
    @(negedge clk);
    chk("unf_r1", regs[1], 32'hC0DE_0000);
`endif

    do_reset();
    do_xfer(1'b0, 16'hFFFF, 40, -1, lat, np, npop, nwe);
    @(negedge clk);
    sif.start    = 1'b1;
    sif.op       = 1'b1;
    sif.reg_mask = 16'hFFFF;
    @(negedge clk);
    sif.start    = 1'b0;
    sif.reg_mask = '0;
    chk("mid_busy", 32'(sif.busy), 32'd1);
    chk("mid_pop", 32'(sif.stk_pop), 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy",  32'(sif.busy),     32'd0);
    chk("arst_pop",   32'(sif.stk_pop),  32'd0);
    chk("arst_we",    32'(sif.rf_we),    32'd0);
    chk("arst_wdata", sif.rf_wdata,      32'd0);
    chk("arst_stall", 32'(sif.stall),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_busy", 32'(sif.busy), 32'd0);
    chk("post_pop",  32'(sif.stk_pop), 32'd0);

    do_xfer(1'b0, 16'h0025, 20, 2, lat, np, npop, nwe);
    chk("ign_lat",  32'(lat),  32'd4);
    chk("ign_push", 32'(np),   32'd3);
    chk("ign_pop",  32'(npop), 32'd0);
    @(negedge clk);
    chk("ign_idle", 32'(sif.busy), 32'd0);
    @(negedge clk);
    chk("ign_idle2", 32'(sif.busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
